// File: rtl/load_scoreboard.sv
// load_scoreboard: pending-write scoreboard for outstanding loads, with RAW/WAW/capacity
// decode stalls and a flush drain sequence (RUN -> DRAIN -> DONE -> RUN).
module load_scoreboard #(
   parameter int MAX_OUT = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ds_valid,
   input  logic [4:0]  ds_raddr1,
   input  logic [4:0]  ds_raddr2,
   input  logic [4:0]  ds_dest,
   input  logic        ds_we,
   input  logic        ds_is_load,
   input  logic        es_allowin,
   input  logic        ld_done_valid,
   input  logic [4:0]  ld_done_dest,
   input  logic        flush_req,
   output logic        ds_stall,
   output logic        ds_fire,
   output logic [31:0] pending_mask,
   output logic [2:0]  out_cnt,
   output logic        flush_done,
   output logic        err_underflow
);
   localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2;
   logic [1:0]  state;
   logic [31:0] clr_mask, set_mask, eff_pend;
   logic        completing, issue, raw, waw, cap, drained;
   always_comb begin
      completing = ld_done_valid && out_cnt != 3'd0;
      clr_mask   = (ld_done_valid && ld_done_dest != 5'd0) ? 32'd1 << ld_done_dest : 32'd0;
      eff_pend   = pending_mask & ~clr_mask;
      raw        = (ds_raddr1 != 5'd0 && eff_pend[ds_raddr1]) || (ds_raddr2 != 5'd0 && eff_pend[ds_raddr2]);
      waw        = ds_we && ds_dest != 5'd0 && eff_pend[ds_dest];
      cap        = ds_is_load && (out_cnt - {2'b0, completing}) == 3'(MAX_OUT);
      // flush_req stalls in RUN too, so nothing issues in the cycle that enters DRAIN
      ds_stall   = ds_valid && (raw || waw || cap || state != RUN || flush_req);
      ds_fire    = ds_valid && !ds_stall && es_allowin;
      issue      = ds_fire && ds_is_load;
      set_mask   = (issue && ds_we && ds_dest != 5'd0) ? 32'd1 << ds_dest : 32'd0;
      drained    = out_cnt == 3'd0 || (out_cnt == 3'd1 && completing);
      flush_done = state == DONE;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= RUN;
         pending_mask  <= 32'd0;
         out_cnt       <= 3'd0;
         err_underflow <= 1'b0;
      end else begin
         state         <= state == RUN ? (flush_req ? DRAIN : RUN) :
                          state == DRAIN ? (drained ? DONE : DRAIN) : RUN;
         pending_mask  <= (state == DRAIN && drained) ? 32'd0 :
                          ((completing ? eff_pend : pending_mask) | set_mask);
         out_cnt       <= out_cnt + {2'b0, issue} - {2'b0, completing};
         err_underflow <= err_underflow || (ld_done_valid && out_cnt == 3'd0);
      end
   end
endmodule

// File: doc/load_scoreboard.md
LOAD_SCOREBOARD -- requirements
Module: load_scoreboard

Interface
REQ-001 Parameter MAX_OUT, default 4, SHALL set the maximum number of outstanding loads (range 1..7).
REQ-002 clk  in  1  single clock; all state SHALL change on the rising edge only.
REQ-003 resetn  in  1  SHALL be an asynchronous, active-low reset.
REQ-004 ds_valid  in  1  decode-stage instruction valid.
REQ-005 ds_raddr1, ds_raddr2  in  5 each  decode source register numbers.
REQ-006 ds_dest  in  5  decode destination register number.
REQ-007 ds_we  in  1  decode instruction writes ds_dest.
REQ-008 ds_is_load  in  1  decode instruction is a load.
REQ-009 es_allowin  in  1  execute stage can accept an instruction.
REQ-010 ld_done_valid  in  1  one load writeback this cycle.
REQ-011 ld_done_dest  in  5  register written by that load.
REQ-012 flush_req  in  1  pipeline flush request (level, held until flush_done).
REQ-013 ds_stall  out  1  decode must hold.
REQ-014 ds_fire  out  1  decode issues this cycle.
REQ-015 pending_mask  out  32  registered pending-write bitmap; bit 0 SHALL always be 0.
REQ-016 out_cnt  out  3  outstanding load count.
REQ-017 flush_done  out  1  one-cycle pulse, drain complete.
REQ-018 err_underflow  out  1  sticky: completion seen with out_cnt==0.

Function
REQ-019 clr_mask SHALL be the one-hot of ld_done_dest when ld_done_valid and ld_done_dest!=0, else 0; eff_pend = pending_mask & ~clr_mask.
REQ-020 RAW hazard SHALL be eff_pend[raddr1] (raddr1!=0) or eff_pend[raddr2] (raddr2!=0).
REQ-021 WAW hazard SHALL be ds_we and ds_dest!=0 and eff_pend[ds_dest].
REQ-022 Capacity hazard SHALL be ds_is_load and (out_cnt - completing) == MAX_OUT, where completing = 1 if ld_done_valid and out_cnt!=0.
REQ-023 ds_stall SHALL be ds_valid and (RAW or WAW or capacity or state != RUN); combinational, zero-cycle latency.
REQ-024 ds_fire SHALL be ds_valid and !ds_stall and es_allowin.
REQ-025 On ds_fire with ds_is_load, ds_we and ds_dest!=0, pending_mask[ds_dest] SHALL be set next cycle.
REQ-026 On ds_fire with ds_is_load, out_cnt SHALL increment, including loads to r0.
REQ-027 Clearing and setting in the same cycle SHALL apply clear first, then set: set wins on the same bit.
REQ-028 out_cnt next = out_cnt + issue - completing; out_cnt SHALL never exceed MAX_OUT or wrap below 0.
REQ-029 When ld_done_valid arrives while out_cnt==0, err_underflow SHALL be set; out_cnt and pending_mask SHALL be unchanged.
REQ-030 States SHALL be RUN, DRAIN and DONE.
REQ-031 RUN -> DRAIN SHALL occur when flush_req=1; no issue SHALL be allowed in the transition cycle (ds_stall forced).
REQ-032 In DRAIN, completions SHALL continue to be retired.
REQ-033 DRAIN -> DONE SHALL occur when out_cnt reaches 0, or when out_cnt==1 and completing=1.
REQ-034 On entering DONE, pending_mask SHALL be cleared and flush_done SHALL pulse for one cycle.
REQ-035 DONE -> RUN SHALL occur unconditionally on the next cycle.
REQ-036 flush_req still high in RUN after DONE SHALL start a new drain.
REQ-037 flush_req asserted with out_cnt==0 SHALL give DRAIN for 1 cycle, then DONE; flush_done SHALL rise 2 cycles after flush_req.

Reset
REQ-038 resetn low SHALL immediately force state=RUN, pending_mask=0, out_cnt=0, flush_done=0 and err_underflow=0.
REQ-039 With ds_valid=0, ds_stall and ds_fire SHALL be 0 during reset.
REQ-040 Reset asserted mid-DRAIN SHALL abandon the drain without emitting flush_done.
REQ-041 Deassertion of resetn SHALL be synchronized externally.

Verification
REQ-042 Load-use: cycle 0 fire load to r5; cycle 1 ds_raddr1=5 -> ds_stall=1 until ld_done_dest=5; in the ld_done cycle ds_stall=0 and ds_fire=1.
REQ-043 r0: load to r0, then raddr1=0 and raddr2=0 -> no stall; pending_mask stays 0; out_cnt=1.
REQ-044 Capacity: MAX_OUT=4, fire 4 loads to r1..r4, 5th load to r6 -> stalled; same-cycle ld_done r1 -> 5th fires; out_cnt stays 4.
REQ-045 Set/clear collision: r7 pending, ld_done r7 and a new load r7 fire together -> bit 7 remains 1; out_cnt unchanged.
REQ-046 Flush: 2 loads outstanding, flush_req=1 -> ds_stall=1; after 2 completions, DONE state, flush_done=1 for one cycle, pending_mask=0; next cycle RUN.
REQ-047 Underflow and reset: ld_done with out_cnt=0 -> err_underflow=1 (sticky); resetn=0 -> all outputs 0 asynchronously, before the next clock edge.
